// File: rtl/instr_fetch.sv
// instr_fetch -- instruction fetch sequencer for a small microcoded controller.
//
// Runs a program from PC 0 on Start, fetching one 9-bit word per instruction
// from an asynchronous-read ROM, presenting it to the decoder for one or more
// EXEC cycles, and advancing PC by +1, by a jump-LUT lookup, or stopping on
// Halt.
//
// Optional feature: define FETCH_ICOUNT_EN to build the retired-instruction
// counter on Icount. Without it Icount is tied to 0.
//
// Ports
//   Clk, Reset_n          clock, async active-low reset
//   Start                 begin a run from PC 0 (IDLE/DONE only)
//   Imem_addr/Imem_data   instruction ROM read port (address always = Pc)
//   mach_code, Valid      instruction register and its EXEC qualifier
//   Stall                 hold in EXEC
//   Jtake, Jptr, Halt     decoder feedback, sampled in EXEC only
//   Lut_we/waddr/wdata    32 x 10 jump-LUT write port (any state)
//   Pc, Done, Icount      status outputs
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for Start after reset
// FETCH | ROM word at Pc loaded into mach_code (one cycle)
// EXEC  | mach_code valid for the decoder; advance unless stalled
// DONE  | halted; Start re-runs from PC 0

module instr_fetch (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Start,
  output logic [9:0] Imem_addr,
  input  logic [8:0] Imem_data,
  output logic [8:0] mach_code,
  output logic       Valid,
  input  logic       Stall,
  input  logic       Jtake,
  input  logic [4:0] Jptr,
  input  logic       Halt,
  input  logic       Lut_we,
  input  logic [4:0] Lut_waddr,
  input  logic [9:0] Lut_wdata,
  output logic [9:0] Pc,
  output logic       Done,
  output logic [15:0] Icount
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE} state_t;

  state_t     state_q, state_d;
  logic [9:0] pc_q, pc_d;
  logic [8:0] ir_q, ir_d;
  logic [9:0] lut_q [32];
  logic [9:0] lut_d [32];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      for (int i = 0; i < 32; i++) lut_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      lut_q   <= lut_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    lut_d   = lut_q;

    if (Lut_we) lut_d[Lut_waddr] = Lut_wdata;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: begin
        ir_d    = Imem_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (!Stall) begin
          if (Halt) begin
            state_d = S_DONE;
          end else if (Jtake) begin
            // lut_q, not lut_d: a same-cycle write to this index is not seen
            pc_d    = lut_q[Jptr];
            state_d = S_FETCH;
          end else begin
            pc_d    = pc_q + 10'd1;
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef FETCH_ICOUNT_EN
  logic [15:0] icount_q, icount_d;
  logic        start_run, retire;

  always_comb begin
    start_run = ((state_q == S_IDLE) || (state_q == S_DONE)) && Start;
    retire    = (state_q == S_EXEC) && !Stall;
    icount_d  = icount_q;
    if (start_run)
      icount_d = '0;
    else if (retire && (icount_q != 16'hFFFF))
      icount_d = icount_q + 16'd1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) icount_q <= '0;
    else          icount_q <= icount_d;
  end

  assign Icount = icount_q;
`else
  assign Icount = '0;
`endif

  assign Imem_addr = pc_q;
  assign Pc        = pc_q;
  assign mach_code = ir_q;
  assign Valid     = (state_q == S_EXEC);
  assign Done      = (state_q == S_DONE);

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        Clk;
  logic        Reset_n;
  logic        Start;
  logic [9:0]  Imem_addr;
  logic [8:0]  Imem_data;
  logic [8:0]  mach_code;
  logic        Valid;
  logic        Stall;
  logic        Jtake;
  logic [4:0]  Jptr;
  logic        Halt;
  logic        Lut_we;
  logic [4:0]  Lut_waddr;
  logic [9:0]  Lut_wdata;
  logic [9:0]  Pc;
  logic        Done;
  logic [15:0] Icount;

  instr_fetch dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start),
    .Imem_addr(Imem_addr), .Imem_data(Imem_data),
    .mach_code(mach_code), .Valid(Valid), .Stall(Stall),
    .Jtake(Jtake), .Jptr(Jptr), .Halt(Halt),
    .Lut_we(Lut_we), .Lut_waddr(Lut_waddr), .Lut_wdata(Lut_wdata),
    .Pc(Pc), .Done(Done), .Icount(Icount)
  );

  logic [8:0] rom [1024];
  assign Imem_data = rom[Imem_addr];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [9:0] pc;
    logic [8:0] code;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_ic = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_ic(input string tag);
`ifdef FETCH_ICOUNT_EN
    chk(tag, 32'(Icount), 32'(exp_ic));
`else
    chk(tag, 32'(Icount), 32'd0);
`endif
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [9:0] p);
    exp_t e;
    e.pc   = p;
    e.code = rom[p];
    sb_q.push_back(e);
  endtask

  // Wait (bounded) for the next EXEC cycle, then compare it to the scoreboard.
  task automatic wait_exec(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (Valid !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    chk({tag, " valid"}, 32'(Valid), 32'd1);
    chk({tag, " fetch latency"}, 32'(n), 32'd1);
    if (sb_q.size() == 0) begin
      chk({tag, " scoreboard empty"}, 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, " pc"}, 32'(Pc), 32'(e.pc));
      chk({tag, " mach_code"}, 32'(mach_code), 32'(e.code));
    end
  endtask

  task automatic advance(input logic jt, input logic [4:0] jp, input logic hl);
    Jtake = jt; Jptr = jp; Halt = hl; Stall = 1'b0;
    step();
    Jtake = 1'b0; Jptr = '0; Halt = 1'b0;
    if (exp_ic < 16'hFFFF) exp_ic++;
  endtask

  task automatic lut_write(input logic [4:0] a, input logic [9:0] d);
    Lut_we = 1'b1; Lut_waddr = a; Lut_wdata = d;
  endtask

  task automatic start_run();
    Start = 1'b1;
    step();
    Start = 1'b0;
    exp_ic = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 9'((i * 37 + 11) ^ (i >> 3));
    rom[0] = 9'h0A1; rom[1] = 9'h0B2; rom[2] = 9'h1C0;
    Start = 0; Stall = 0; Jtake = 0; Jptr = 0; Halt = 0;
    Lut_we = 0; Lut_waddr = 0; Lut_wdata = 0;

    // reset is visible before any clock edge
    Reset_n = 1'b1;
    #1 Reset_n = 1'b0;
    #2;
    chk("rst pc", 32'(Pc), 32'd0);
    chk("rst imem_addr", 32'(Imem_addr), 32'd0);
    chk("rst mach_code", 32'(mach_code), 32'd0);
    chk("rst valid", 32'(Valid), 32'd0);
    chk("rst done", 32'(Done), 32'd0);
    chk_ic("rst icount");
    step(); step();
    Reset_n = 1'b1;
    step();
    chk("idle valid", 32'(Valid), 32'd0);

    // three-instruction program ending in Halt
    start_run();
    chk("A fetch valid", 32'(Valid), 32'd0);
    chk("A fetch addr", 32'(Imem_addr), 32'd0);
    push(10'd0); wait_exec("A0");
    advance(0, 0, 0);
    push(10'd1); wait_exec("A1");
    advance(0, 0, 0);
    push(10'd2); wait_exec("A2");
    advance(0, 0, 1);
    chk("A done", 32'(Done), 32'd1);
    chk("A done valid", 32'(Valid), 32'd0);
    chk("A done pc", 32'(Pc), 32'd2);
    chk_ic("A icount");
    Jtake = 1'b1; Jptr = 5'd0;
    step();
    Jtake = 1'b0;
    chk("A jtake ignored in done", 32'(Pc), 32'd2);
    chk("A stays done", 32'(Done), 32'd1);

    // jump through LUT[5]=300 at Pc=7
    lut_write(5'd5, 10'd300);
    step();
    Lut_we = 1'b0;
    start_run();
    chk("B done cleared", 32'(Done), 32'd0);
    for (int i = 0; i < 7; i++) begin
      push(10'(i)); wait_exec("B seq");
      advance(0, 0, 0);
    end
    push(10'd7); wait_exec("B pc7");
    advance(1, 5'd5, 0);
    chk("B jump addr", 32'(Imem_addr), 32'd300);
    chk("B jump fetch valid", 32'(Valid), 32'd0);
    push(10'd300); wait_exec("B at300");
    chk_ic("B icount");

    // stall holds for 3 cycles, Halt ignored while stalled; LUT written in EXEC
    Stall = 1'b1; Halt = 1'b1;
    lut_write(5'd6, 10'd1023);
    for (int i = 0; i < 3; i++) begin
      step();
      Lut_we = 1'b0;
      chk("C stall valid", 32'(Valid), 32'd1);
      chk("C stall pc", 32'(Pc), 32'd300);
      chk("C stall code", 32'(mach_code), 32'(rom[300]));
    end
    chk_ic("C stall icount");
    advance(0, 0, 0);
    chk("C release pc", 32'(Pc), 32'd301);
    chk("C release valid", 32'(Valid), 32'd0);

    // wrap 1023 -> 0, then Halt+Jtake together
    push(10'd301); wait_exec("D 301");
    advance(1, 5'd6, 0);
    chk("D jump 1023", 32'(Pc), 32'd1023);
    push(10'd1023); wait_exec("D 1023");
    advance(0, 0, 0);
    chk("D wrap pc", 32'(Pc), 32'd0);
    push(10'd0); wait_exec("D 0");
    advance(1, 5'd6, 1);
    chk("D halt prio done", 32'(Done), 32'd1);
    chk("D halt prio pc", 32'(Pc), 32'd0);
    chk_ic("D icount");

    // same-cycle LUT write and jump uses old value
    lut_write(5'd3, 10'd20);
    step();
    Lut_we = 1'b0;
    start_run();
    push(10'd0); wait_exec("E 0");
    lut_write(5'd3, 10'd50);
    advance(1, 5'd3, 0);
    Lut_we = 1'b0;
    chk("E old lut value", 32'(Pc), 32'd20);
    push(10'd20); wait_exec("E 20");
    advance(1, 5'd3, 0);
    chk("E new lut value", 32'(Pc), 32'd50);

    // reset mid-EXEC at Pc=40
    push(10'd50); wait_exec("F 50");
    lut_write(5'd4, 10'd40);
    advance(1, 5'd3, 0);
    Lut_we = 1'b0;
    push(10'd50); wait_exec("F 50b");
    advance(1, 5'd4, 0);
    chk("F jump 40", 32'(Pc), 32'd40);
    push(10'd40); wait_exec("F 40");
    Reset_n = 1'b0;
    #2;
    exp_ic = 0;
    chk("F rst pc", 32'(Pc), 32'd0);
    chk("F rst valid", 32'(Valid), 32'd0);
    chk("F rst done", 32'(Done), 32'd0);
    chk("F rst code", 32'(mach_code), 32'd0);
    chk_ic("F rst icount");
    step(); step();
    Reset_n = 1'b1;
    step(); step();
    chk("F idle valid", 32'(Valid), 32'd0);
    chk("F idle done", 32'(Done), 32'd0);
    chk("F idle pc", 32'(Pc), 32'd0);
    start_run();
    push(10'd0); wait_exec("F restart");
    advance(1, 5'd4, 0);
    chk("F lut cleared", 32'(Pc), 32'd0);
    chk_ic("F icount");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have port Clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port Start  input  1  level-sampled request to begin a program run from PC 0.
REQ-004 SHALL have port Imem_addr  output  10  instruction ROM address (asynchronous-read ROM).
REQ-005 SHALL have port Imem_data  input  9  instruction word at Imem_addr.
REQ-006 SHALL have port mach_code  output  9  instruction register, feeds the control decoder.
REQ-007 SHALL have port Valid  output  1  mach_code holds an instruction the decoder must act on this cycle.
REQ-008 SHALL have port Stall  input  1  downstream hold request, honoured only in EXEC.
REQ-009 SHALL have port Jtake  input  1  decoder reports a taken jump this cycle.
REQ-010 SHALL have port Jptr  input  5  decoder jump-LUT index.
REQ-011 SHALL have port Halt  input  1  decoder reports halt instruction.
REQ-012 SHALL have ports Lut_we (input, 1), Lut_waddr (input, 5), Lut_wdata (input, 10)  jump-LUT write port.
REQ-013 SHALL have port Pc  output  10  current program counter.
REQ-014 SHALL have port Done  output  1  program halted.
REQ-015 SHALL have port Icount  output  16  retired-instruction count (see Configuration).

Function
REQ-016 SHALL implement states IDLE, FETCH, EXEC, DONE.
REQ-017 IDLE: Start=1 -> FETCH with Pc=0; otherwise stay.
REQ-018 FETCH: Imem_addr=Pc; at the clock edge, mach_code<=Imem_data; -> EXEC (exactly 1 cycle).
REQ-019 EXEC: Valid=1; Stall=1 -> hold state, Pc, and mach_code.
REQ-020 EXEC, Stall=0, Halt=1 -> DONE; Pc unchanged; Halt has priority over Jtake.
REQ-021 EXEC, Stall=0, Jtake=1, Halt=0 -> Pc<=LUT[Jptr]; -> FETCH.
REQ-022 EXEC, Stall=0, otherwise -> Pc<=Pc+1 modulo 1024 (1023 wraps to 0); -> FETCH.
REQ-023 Valid SHALL be 0 outside EXEC; Jtake, Halt, and Jptr SHALL be ignored outside EXEC.
REQ-024 DONE: Done=1; Start=1 -> FETCH with Pc=0 and Done cleared; Start SHALL be ignored in FETCH and EXEC.
REQ-025 Jump LUT: 32 x 10-bit; write occurs on Lut_we in any state.
REQ-026 On a LUT write and a jump to the same index in the same cycle, the jump SHALL use the pre-write value.
REQ-027 Imem_addr SHALL equal Pc in all states.

Reset
REQ-028 While Reset_n=0, the block SHALL be in IDLE with Pc=0, mach_code=0, Valid=0, Done=0, Icount=0, and all LUT entries 0; this applies immediately, without a clock edge.
REQ-029 Reset asserted mid-run SHALL abort the run; after release the block SHALL wait in IDLE for Start.

Configuration
REQ-030 Macro FETCH_ICOUNT_EN: when defined, Icount SHALL increment (saturating at 16'hFFFF) on every EXEC cycle with Stall=0, including the halting instruction, and SHALL be cleared on each IDLE/DONE->FETCH start.
REQ-031 When FETCH_ICOUNT_EN is undefined, Icount SHALL be constant 0 and SHALL have no counter logic.

Verification
REQ-032 Reset, Start pulse, ROM[0..2] = 9'h0A1, 9'h0B2, 9'h1C0 (Halt on word 2) -> Valid high on cycles 2, 4, 6 after Start with matching mach_code; Done=1 after the third EXEC; Icount=3 when FETCH_ICOUNT_EN is defined.
REQ-033 Write LUT[5]=10'd300, then Jtake=1 with Jptr=5 in EXEC at Pc=7 -> next FETCH has Imem_addr=300.
REQ-034 Stall=1 for 3 cycles in EXEC -> Valid stays 1, and Pc and mach_code are unchanged for those 3 cycles; advance occurs on the first Stall=0 cycle.
REQ-035 Pc=1023 with no jump -> next Pc=0; Halt=1 and Jtake=1 together -> DONE with Pc unchanged.
REQ-036 Reset_n pulled low mid-EXEC at Pc=40 -> Pc=0, Valid=0, and IDLE immediately; LUT reads back 0.
REQ-037 LUT[3] written to 50 in the same cycle as a jump via Jptr=3 whose old value is 20 -> Pc=20; a later jump via index 3 -> Pc=50.
